// File: rtl/housekeeping_pkg.sv
// Shared types and constants for the housekeeping SPI-to-register-bank bridge.
// Holds the bridge FSM encoding, the bank request payload, the locally answered
// address map (0-7) and the byte returned when a bank read expires.
package housekeeping_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WREQ  = 2'd1,
    ST_RREQ  = 2'd2,
    ST_RDONE = 2'd3
  } hk_state_e;

  // Register-bank request payload as presented on reg_we/reg_addr/reg_wdata.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } hk_req_t;

  // Locally answered addresses.
  localparam logic [ADDR_W-1:0] ADDR_MODE      = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_MFGR_LO   = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_MFGR_HI   = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_PROD      = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_MASK_B3   = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_MASK_B2   = 8'h05;
  localparam logic [ADDR_W-1:0] ADDR_MASK_B1   = 8'h06;
  localparam logic [ADDR_W-1:0] ADDR_MASK_B0   = 8'h07;
  localparam logic [ADDR_W-1:0] ADDR_LOCAL_END = 8'h08;

  // Byte handed back to the SPI slave when a bank read never acknowledges.
  localparam logic [DATA_W-1:0] TIMEOUT_BYTE = 8'hFF;

  function automatic logic is_local(input logic [ADDR_W-1:0] addr);
    return addr < ADDR_LOCAL_END;
  endfunction

endpackage

// File: rtl/housekeeping_sync_edge.sv
// Two-flop synchronizer with history flop and registered rising-edge pulse.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   strobe     : asynchronous level input (SCK-domain strobe)
//   rise       : one-cycle pulse, high in the cycle after sync2 & ~sync3 was seen
module housekeeping_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic sync3_q;

  // The edge pulse is registered so the downstream FSM sees a clean flop output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      rise    <= 1'b0;
    end else begin
      sync1_q <= strobe;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise    <= sync2_q & ~sync3_q;
    end
  end

endmodule

// File: rtl/housekeeping_spi_bridge.sv
// Bridge from the SCK-clocked housekeeping SPI slave to the register bank on
// wb_clk_i. Synchronized strobes become single request/ack transactions;
// addresses 0-7 are answered locally and a bounded timeout guarantees a byte.
// Ports:
//   wb_clk_i, wb_rstn_i     : clock, synchronous active-low reset
//   spi_wrstb, spi_rdstb    : asynchronous strobes from the SPI slave
//   spi_addr, spi_wdata     : SPI address / write data (stable after strobe)
//   spi_rdata               : read byte to the SPI slave, held between updates
//   reg_req/we/addr/wdata   : register-bank request
//   reg_rdata, reg_ack      : register-bank response
//   overrun, timeout        : sticky status flags
module housekeeping_spi_bridge
  import housekeeping_pkg::*;
#(
  parameter logic [11:0] MFGR_ID = 12'h456,
  parameter logic [7:0]  PROD_ID = 8'h11,
  parameter logic [31:0] MASK_ID = 32'h0,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              spi_wrstb,
  input  logic              spi_rdstb,
  input  logic [ADDR_W-1:0] spi_addr,
  input  logic [DATA_W-1:0] spi_wdata,
  output logic [DATA_W-1:0] spi_rdata,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  input  logic              reg_ack,
  output logic              overrun,
  output logic              timeout
);

  logic wr_rise;
  logic rd_rise;

  housekeeping_sync_edge u_wr_sync (
    .clk    (wb_clk_i),
    .rst_n  (wb_rstn_i),
    .strobe (spi_wrstb),
    .rise   (wr_rise)
  );

  housekeeping_sync_edge u_rd_sync (
    .clk    (wb_clk_i),
    .rst_n  (wb_rstn_i),
    .strobe (spi_rdstb),
    .rise   (rd_rise)
  );

  // Local address map: mode flags, manufacturer/product/mask IDs.
  function automatic logic [DATA_W-1:0] local_byte(input logic [ADDR_W-1:0] addr);
    case (addr)
      ADDR_MFGR_LO: return MFGR_ID[7:0];
      ADDR_MFGR_HI: return {4'h0, MFGR_ID[11:8]};
      ADDR_PROD:    return PROD_ID;
      ADDR_MASK_B3: return MASK_ID[31:24];
      ADDR_MASK_B2: return MASK_ID[23:16];
      ADDR_MASK_B1: return MASK_ID[15:8];
      ADDR_MASK_B0: return MASK_ID[7:0];
      default:      return 8'h00;
    endcase
  endfunction

  hk_state_e         state_q,     state_d;
  hk_req_t           req_q,       req_d;
  logic              req_valid_q, req_valid_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [DATA_W-1:0] rd_byte_q,   rd_byte_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              pend_q,      pend_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic              overrun_q,   overrun_d;
  logic              timeout_q,   timeout_d;

  // State and output registers.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rstn_i) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      cnt_q       <= '0;
      rd_byte_q   <= '0;
      rdata_q     <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      cnt_q       <= cnt_d;
      rd_byte_q   <= rd_byte_d;
      rdata_q     <= rdata_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    logic              rd_go;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  cnt_inc;

    state_d     = state_q;
    req_d       = req_q;
    req_valid_d = req_valid_q;
    cnt_d       = cnt_q;
    rd_byte_d   = rd_byte_q;
    rdata_d     = rdata_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;

    cnt_inc = cnt_q + CNT_W'(1);
    // A held read takes priority over fresh edges; a lone read edge is served
    // directly, while a read arriving with a write waits in the pending slot.
    rd_go   = pend_q | (rd_rise & ~wr_rise);
    rd_addr = pend_q ? pend_addr_q : spi_addr;

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          if (wr_rise || rd_rise) overrun_d = 1'b1;
        end else if (wr_rise) begin
          if (!is_local(spi_addr)) begin
            state_d     = ST_WREQ;
            req_valid_d = 1'b1;
            req_d       = '{we: 1'b1, addr: spi_addr, wdata: spi_wdata};
            cnt_d       = '0;
          end
          if (rd_rise) begin
            pend_d      = 1'b1;
            pend_addr_d = spi_addr;
          end
        end

        if (rd_go) begin
          if (is_local(rd_addr)) begin
            state_d   = ST_RDONE;
            rd_byte_d = local_byte(rd_addr);
          end else begin
            state_d     = ST_RREQ;
            req_valid_d = 1'b1;
            req_d       = '{we: 1'b0, addr: rd_addr, wdata: req_q.wdata};
            cnt_d       = '0;
          end
        end
      end

      ST_WREQ, ST_RREQ: begin
        if (wr_rise || rd_rise) overrun_d = 1'b1;
        // An ack in the expiry cycle still completes the transaction normally.
        if (reg_ack) begin
          req_valid_d = 1'b0;
          req_d.we    = 1'b0;
          if (state_q == ST_RREQ) begin
            rd_byte_d = reg_rdata;
            state_d   = ST_RDONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          req_valid_d = 1'b0;
          req_d.we    = 1'b0;
          timeout_d   = 1'b1;
          if (state_q == ST_RREQ) begin
            rd_byte_d = TIMEOUT_BYTE;
            state_d   = ST_RDONE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      ST_RDONE: begin
        if (wr_rise || rd_rise) overrun_d = 1'b1;
        rdata_d = rd_byte_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign spi_rdata = rdata_q;
  assign reg_req   = req_valid_q;
  assign reg_we    = req_q.we;
  assign reg_addr  = req_q.addr;
  assign reg_wdata = req_q.wdata;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_housekeeping_spi_bridge.sv
// Directed self-checking bench for housekeeping_spi_bridge (default parameters).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_housekeeping_spi_bridge;

  logic       wb_clk_i = 1'b0;
  logic       wb_rstn_i;
  logic       spi_wrstb;
  logic       spi_rdstb;
  logic [7:0] spi_addr;
  logic [7:0] spi_wdata;
  logic [7:0] spi_rdata;
  logic       reg_req;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       overrun;
  logic       timeout;

  int vectors = 0;
  int errors  = 0;

  housekeeping_spi_bridge dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rstn_i (wb_rstn_i),
    .spi_wrstb (spi_wrstb),
    .spi_rdstb (spi_rdstb),
    .spi_addr  (spi_addr),
    .spi_wdata (spi_wdata),
    .spi_rdata (spi_rdata),
    .reg_req   (reg_req),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    wb_rstn_i = 1'b0;
    spi_wrstb = 1'b0;
    spi_rdstb = 1'b0;
    spi_addr  = 8'h00;
    spi_wdata = 8'h00;
    reg_rdata = 8'h00;
    reg_ack   = 1'b0;
    tick(3);
    chk("rst_req",     32'(reg_req),   32'h0);
    chk("rst_we",      32'(reg_we),    32'h0);
    chk("rst_addr",    32'(reg_addr),  32'h0);
    chk("rst_wdata",   32'(reg_wdata), 32'h0);
    chk("rst_rdata",   32'(spi_rdata), 32'h0);
    chk("rst_overrun", 32'(overrun),   32'h0);
    chk("rst_timeout", 32'(timeout),   32'h0);
    wb_rstn_i = 1'b1;
    tick(2);

    // Bank write 0x0C <- 0xA5; strobe first sampled at edge k.
    spi_addr  = 8'h0C;
    spi_wdata = 8'hA5;
    spi_wrstb = 1'b1;
    tick(3);
    chk("wr_req_k2", 32'(reg_req), 32'h0);
    tick(1);
    chk("wr_req_k3",  32'(reg_req),   32'h1);
    chk("wr_we",      32'(reg_we),    32'h1);
    chk("wr_addr",    32'(reg_addr),  32'h0C);
    chk("wr_wdata",   32'(reg_wdata), 32'hA5);
    tick(2);
    chk("wr_req_hold", 32'(reg_req), 32'h1);
    reg_ack   = 1'b1;
    spi_wrstb = 1'b0;
    tick(1);
    reg_ack = 1'b0;
    chk("wr_req_drop", 32'(reg_req), 32'h0);
    chk("wr_overrun",  32'(overrun), 32'h0);
    chk("wr_timeout",  32'(timeout), 32'h0);
    tick(4);

    // Local read of product ID at address 3.
    spi_addr  = 8'h03;
    spi_rdstb = 1'b1;
    tick(4);
    chk("loc_no_req",    32'(reg_req),   32'h0);
    chk("loc_rdata_k3",  32'(spi_rdata), 32'h00);
    tick(1);
    chk("loc_rdata_k4",  32'(spi_rdata), 32'h11);
    spi_rdstb = 1'b0;
    tick(4);

    // Bank read 0x20, acked after 4 request cycles with 0x3C.
    spi_addr  = 8'h20;
    spi_rdstb = 1'b1;
    tick(4);
    chk("rd_req",  32'(reg_req),  32'h1);
    chk("rd_we",   32'(reg_we),   32'h0);
    chk("rd_addr", 32'(reg_addr), 32'h20);
    tick(3);
    reg_ack   = 1'b1;
    reg_rdata = 8'h3C;
    spi_rdstb = 1'b0;
    tick(1);
    reg_ack = 1'b0;
    chk("rd_req_drop",  32'(reg_req),   32'h0);
    chk("rd_rdata_n1",  32'(spi_rdata), 32'h11);
    tick(1);
    chk("rd_rdata_n2",  32'(spi_rdata), 32'h3C);
    tick(4);

    // Bank read 0x20 that never acks: request lasts exactly 15 cycles.
    spi_rdstb = 1'b1;
    tick(4);
    chk("to_req_first", 32'(reg_req), 32'h1);
    spi_rdstb = 1'b0;
    tick(14);
    chk("to_req_last",  32'(reg_req), 32'h1);
    chk("to_flag_pre",  32'(timeout), 32'h0);
    tick(1);
    chk("to_req_drop",  32'(reg_req), 32'h0);
    chk("to_flag",      32'(timeout), 32'h1);
    tick(1);
    chk("to_rdata",     32'(spi_rdata), 32'hFF);
    tick(4);

    // Simultaneous write and read edges: write first, then the held read.
    spi_addr  = 8'h30;
    spi_wdata = 8'h5A;
    spi_wrstb = 1'b1;
    spi_rdstb = 1'b1;
    tick(4);
    chk("m11_wr_req",  32'(reg_req),  32'h1);
    chk("m11_wr_we",   32'(reg_we),   32'h1);
    chk("m11_wr_addr", 32'(reg_addr), 32'h30);
    reg_ack   = 1'b1;
    spi_wrstb = 1'b0;
    spi_rdstb = 1'b0;
    tick(1);
    reg_ack = 1'b0;
    chk("m11_wr_drop", 32'(reg_req), 32'h0);
    tick(1);
    chk("m11_rd_req",  32'(reg_req),  32'h1);
    chk("m11_rd_we",   32'(reg_we),   32'h0);
    chk("m11_rd_addr", 32'(reg_addr), 32'h30);
    reg_rdata = 8'h77;
    reg_ack   = 1'b1;
    tick(1);
    reg_ack = 1'b0;
    chk("m11_rd_drop", 32'(reg_req), 32'h0);
    tick(1);
    chk("m11_rdata",   32'(spi_rdata), 32'h77);
    chk("m11_overrun", 32'(overrun),   32'h0);
    tick(4);

    // Second write edge during WREQ is dropped; then reset mid-request.
    spi_addr  = 8'h40;
    spi_wdata = 8'h01;
    spi_wrstb = 1'b1;
    tick(4);
    chk("ov_req",  32'(reg_req),  32'h1);
    chk("ov_addr", 32'(reg_addr), 32'h40);
    spi_wrstb = 1'b0;
    tick(4);
    spi_addr  = 8'h50;
    spi_wrstb = 1'b1;
    tick(4);
    chk("ov_flag",     32'(overrun),  32'h1);
    chk("ov_req_hold", 32'(reg_req),  32'h1);
    chk("ov_addr_kept", 32'(reg_addr), 32'h40);
    spi_wrstb = 1'b0;
    wb_rstn_i = 1'b0;
    tick(1);
    chk("mrst_req",     32'(reg_req),   32'h0);
    chk("mrst_we",      32'(reg_we),    32'h0);
    chk("mrst_addr",    32'(reg_addr),  32'h0);
    chk("mrst_wdata",   32'(reg_wdata), 32'h0);
    chk("mrst_rdata",   32'(spi_rdata), 32'h0);
    chk("mrst_overrun", 32'(overrun),   32'h0);
    chk("mrst_timeout", 32'(timeout),   32'h0);
    wb_rstn_i = 1'b1;
    tick(3);
    chk("post_rst_req", 32'(reg_req), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
